// File: rtl/brew_timer.sv
// Countdown timer for the coffee-maker FSM: loads up to 99 seconds, counts down at a
// speed-scaled rate, reports remaining time in binary and BCD, pulses t_expired at zero.
module brew_timer #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned ACC_W    = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] duration,
    input  logic       abort,
    input  logic       hold,
    input  logic [3:0] speed,
    output logic       busy,
    output logic       t_expired,
    output logic [6:0] remaining,
    output logic [3:0] rem_tens,
    output logic [3:0] rem_ones
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HOLD,
        S_EXPIRE
    } state_t;

    localparam logic [ACC_W-1:0] TICK = ACC_W'(TICK_DIV);

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [6:0]       r_rem;
    logic [3:0]       r_tens;
    logic [3:0]       r_ones;

    logic [3:0]       w_step;
    logic [ACC_W-1:0] w_sum;
    logic             w_tick;
    logic [6:0]       w_load;
    logic [3:0]       w_load_tens;
    logic [3:0]       w_load_ones;

    assign w_step = (speed == 4'd0) ? 4'd1 : speed;
    assign w_sum  = r_acc + ACC_W'(w_step);
    assign w_tick = (w_sum >= TICK);
    assign w_load = (duration > 8'd99) ? 7'd99 : duration[6:0];

    // Split the clamped load value into BCD digits once, at load time.
    always_comb begin
        w_load_tens = '0;
        for (int unsigned i = 1; i < 10; i++) begin
            if (w_load >= 7'(i * 10)) begin
                w_load_tens = 4'(i);
            end
        end
        w_load_ones = 4'(w_load - {3'b000, w_load_tens} * 7'd10);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_rem   <= '0;
            r_tens  <= '0;
            r_ones  <= '0;
        end else if (abort) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_rem   <= '0;
            r_tens  <= '0;
            r_ones  <= '0;
        end else if (start) begin
            r_acc <= '0;
            if (duration == 8'd0) begin
                r_state <= S_EXPIRE;
                r_rem   <= '0;
                r_tens  <= '0;
                r_ones  <= '0;
            end else begin
                r_state <= S_RUN;
                r_rem   <= w_load;
                r_tens  <= w_load_tens;
                r_ones  <= w_load_ones;
            end
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_IDLE;
                S_EXPIRE: r_state <= S_IDLE;
                S_RUN, S_HOLD: begin
                    // The edge that sees hold drop already accumulates, so the countdown
                    // freezes for exactly as many edges as hold was sampled high.
                    if (hold) begin
                        r_state <= S_HOLD;
                    end else begin
                        r_state <= S_RUN;
                        if (w_tick) begin
                            r_acc <= w_sum - TICK;
                            r_rem <= r_rem - 7'd1;
                            if (r_ones == 4'd0) begin
                                r_ones <= 4'd9;
                                r_tens <= r_tens - 4'd1;
                            end else begin
                                r_ones <= r_ones - 4'd1;
                            end
                            if (r_rem == 7'd1) begin
                                r_state <= S_EXPIRE;
                            end
                        end else begin
                            r_acc <= w_sum;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (r_state == S_RUN) || (r_state == S_HOLD);
    assign t_expired = (r_state == S_EXPIRE);
    assign remaining = r_rem;
    assign rem_tens  = r_tens;
    assign rem_ones  = r_ones;

endmodule
